// File: rtl/tcp_logger_record_ctrl.sv
// rtl/tcp_logger_record_ctrl.sv - packet sequencing and log-commit control FSM for the TCP logger record tile
// Optional dropped-packet counter: define TCP_LOGGER_RECORD_DROP_CNT_EN.
module tcp_logger_record_ctrl #(
  parameter int unsigned DROP_CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noc0_logger_record_val,
  output logic logger_record_noc0_rdy,
  output logic logger_record_noc0_val,
  input  logic noc0_logger_record_rdy,
  output logic ctrl_datap_store_hdr,
  output logic ctrl_datap_mod_hdr_flit,
  output logic ctrl_datap_store_len,
  output logic ctrl_datap_incr_num_flits,
  output logic ctrl_datap_incr_addr,
  output logic ctrl_wr_logger_mem_val,
  input  logic datap_ctrl_last_flit,
  input  logic datap_ctrl_no_body,
  input  logic datap_ctrl_log_full,
  input  logic record_en
`ifdef TCP_LOGGER_RECORD_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] dropped_cnt
`endif
);

  typedef enum logic [1:0] {
    HDR,
    META,
    TCP_HDR,
    BODY
  } state_e;

  state_e state_q, state_d;
  logic   xfer;

  assign logger_record_noc0_val = noc0_logger_record_val;
  assign logger_record_noc0_rdy = noc0_logger_record_rdy;
  assign xfer = noc0_logger_record_val & noc0_logger_record_rdy;

  always_comb begin
    state_d                   = state_q;
    ctrl_datap_store_hdr      = 1'b0;
    ctrl_datap_mod_hdr_flit   = 1'b0;
    ctrl_datap_store_len      = 1'b0;
    ctrl_datap_incr_num_flits = 1'b0;
    ctrl_datap_incr_addr      = 1'b0;
    ctrl_wr_logger_mem_val    = 1'b0;
    case (state_q)
      HDR: begin
        // Held for the whole header phase so egress data is stable under backpressure.
        ctrl_datap_mod_hdr_flit = 1'b1;
        if (xfer) begin
          ctrl_datap_store_hdr = 1'b1;
          state_d              = datap_ctrl_no_body ? HDR : META;
        end
      end
      META: begin
        if (xfer) begin
          ctrl_datap_store_len      = 1'b1;
          ctrl_datap_incr_num_flits = 1'b1;
          state_d                   = datap_ctrl_last_flit ? HDR : TCP_HDR;
        end
      end
      TCP_HDR: begin
        if (xfer) begin
          ctrl_datap_incr_num_flits = 1'b1;
          if (record_en && !datap_ctrl_log_full) begin
            ctrl_wr_logger_mem_val = 1'b1;
            ctrl_datap_incr_addr   = 1'b1;
          end
          state_d = datap_ctrl_last_flit ? HDR : BODY;
        end
      end
      BODY: begin
        if (xfer) begin
          ctrl_datap_incr_num_flits = 1'b1;
          if (datap_ctrl_last_flit) state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
    // Reset forces every control strobe low immediately, not just at the next edge.
    if (!rst_n) begin
      ctrl_datap_store_hdr      = 1'b0;
      ctrl_datap_mod_hdr_flit   = 1'b0;
      ctrl_datap_store_len      = 1'b0;
      ctrl_datap_incr_num_flits = 1'b0;
      ctrl_datap_incr_addr      = 1'b0;
      ctrl_wr_logger_mem_val    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HDR;
    else        state_q <= state_d;
  end

`ifdef TCP_LOGGER_RECORD_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] dropped_cnt_q, dropped_cnt_d;

  always_comb begin
    dropped_cnt_d = dropped_cnt_q;
    if (state_q == TCP_HDR && xfer && record_en && datap_ctrl_log_full &&
        dropped_cnt_q != {DROP_CNT_W{1'b1}}) begin
      dropped_cnt_d = dropped_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dropped_cnt_q <= '0;
    else        dropped_cnt_q <= dropped_cnt_d;
  end

  assign dropped_cnt = dropped_cnt_q;
`endif

endmodule

// File: tb/tb_tcp_logger_record_ctrl.sv
// tb/tb_tcp_logger_record_ctrl.sv - scoreboard bench for tcp_logger_record_ctrl
// Drop-counter checks are active when TCP_LOGGER_RECORD_DROP_CNT_EN is defined.
module tb_tcp_logger_record_ctrl;

  typedef struct packed {
    logic sh;
    logic mh;
    logic sl;
    logic inc;
    logic ia;
    logic wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_val, out_rdy_in;
  logic out_val, in_rdy_out;
  logic store_hdr, mod_hdr, store_len, incr_nf, incr_addr, wr_val;
  logic last_flit, no_body, log_full, rec_en;

  int   checks = 0;
  int   errors = 0;
  int   drops  = 0;
  exp_t exp_q[$];

`ifdef TCP_LOGGER_RECORD_DROP_CNT_EN
  localparam int DMAX = 3;
  logic [1:0] dropped_cnt;
`else
  localparam int DMAX = 0;
`endif

  always #5 clk = ~clk;

`ifdef TCP_LOGGER_RECORD_DROP_CNT_EN
  tcp_logger_record_ctrl #(.DROP_CNT_W(2)) dut (
`else
  tcp_logger_record_ctrl dut (
`endif
    .clk                       (clk),
    .rst_n                     (rst_n),
    .noc0_logger_record_val    (in_val),
    .logger_record_noc0_rdy    (in_rdy_out),
    .logger_record_noc0_val    (out_val),
    .noc0_logger_record_rdy    (out_rdy_in),
    .ctrl_datap_store_hdr      (store_hdr),
    .ctrl_datap_mod_hdr_flit   (mod_hdr),
    .ctrl_datap_store_len      (store_len),
    .ctrl_datap_incr_num_flits (incr_nf),
    .ctrl_datap_incr_addr      (incr_addr),
    .ctrl_wr_logger_mem_val    (wr_val),
    .datap_ctrl_last_flit      (last_flit),
    .datap_ctrl_no_body        (no_body),
    .datap_ctrl_log_full       (log_full),
    .record_en                 (rec_en)
`ifdef TCP_LOGGER_RECORD_DROP_CNT_EN
    ,
    .dropped_cnt               (dropped_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [5:0] got_vec();
    return {store_hdr, mod_hdr, store_len, incr_nf, incr_addr, wr_val};
  endfunction

  // Monitor: every xfer consumes one expected flit; idle cycles must carry no strobes.
  always @(negedge clk) begin
    exp_t e;
    chk("fwd_val", {31'd0, out_val}, {31'd0, in_val});
    chk("fwd_rdy", {31'd0, in_rdy_out}, {31'd0, out_rdy_in});
    if (!rst_n) begin
      chk("reset_outputs", {26'd0, got_vec()}, 32'd0);
    end else if (in_val && out_rdy_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got strobes %0h expected no transfer", got_vec());
      end else begin
        e = exp_q.pop_front();
        chk("xfer_strobes", {26'd0, got_vec()}, {26'd0, e});
      end
    end else begin
      e = '0;
      e.mh = (exp_q.size() == 0) ? 1'b1 : exp_q[0].mh;
      chk("idle_strobes", {26'd0, got_vec()}, {26'd0, e});
    end
  end

  // Sends flits 0..min(len, nfl-1) of a packet with msg_len = len.
  task automatic send_pkt(input int len, input bit r, input bit f, input int nfl,
                          input int stall_flit, input bit fast);
    for (int i = 0; i <= len && i < nfl; i++) begin
      exp_t e;
      int   tries;
      bit   done;
      e.sh  = (i == 0);
      e.mh  = (i == 0);
      e.sl  = (i == 1);
      e.inc = (i >= 1);
      e.wr  = (i == 2) && r && !f;
      e.ia  = e.wr;
      exp_q.push_back(e);
      tries = 0;
      done  = 1'b0;
      while (!done) begin
        if (i == stall_flit && tries < 5) begin
          in_val = 1'b1; out_rdy_in = 1'b0;
        end else if (fast || tries >= 16) begin
          in_val = 1'b1; out_rdy_in = 1'b1;
        end else begin
          in_val     = ($urandom_range(0, 3) != 0);
          out_rdy_in = ($urandom_range(0, 3) != 0);
        end
        no_body   = (i == 0) && (len == 0);
        last_flit = (i == len) && (i > 0);
        rec_en    = (i == 2) ? r : 1'($urandom);
        log_full  = (i == 2) ? f : 1'($urandom);
        @(posedge clk);
        done = in_val && out_rdy_in;
        tries++;
        #1;
      end
      if (i == 2 && r && f && drops < DMAX) drops++;
    end
    in_val     = 1'b0;
    out_rdy_in = 1'b0;
  endtask

  task automatic chk_drops(input string name);
`ifdef TCP_LOGGER_RECORD_DROP_CNT_EN
    chk(name, {30'd0, dropped_cnt}, drops);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_val = 1'b0; out_rdy_in = 1'b0;
    last_flit = 1'b0; no_body = 1'b0; log_full = 1'b0; rec_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_drops("drop_reset");

    send_pkt(3, 1'b1, 1'b0, 99, -1, 1'b1);
    send_pkt(3, 1'b1, 1'b0, 99, 2, 1'b1);
    send_pkt(0, 1'b1, 1'b0, 99, -1, 1'b1);
    send_pkt(1, 1'b1, 1'b0, 99, -1, 1'b1);
    send_pkt(2, 1'b1, 1'b0, 99, -1, 1'b1);

    for (int k = 0; k < 3; k++) send_pkt(3, 1'b0, 1'b1, 99, -1, 1'b1);
    chk_drops("drop_rec_off");
    for (int k = 0; k < 3; k++) send_pkt(3, 1'b1, 1'b1, 99, -1, 1'b1);
    chk_drops("drop_three");
    for (int k = 0; k < 2; k++) send_pkt(2, 1'b1, 1'b1, 99, -1, 1'b0);
    chk_drops("drop_saturate");

    for (int k = 0; k < 40; k++) begin
      send_pkt(int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 99, -1, 1'b0);
    end
    chk_drops("drop_random");

    // Truncate a 6-flit packet in BODY with an asynchronous reset.
    send_pkt(5, 1'b1, 1'b0, 4, -1, 1'b1);
    in_val = 1'b1; out_rdy_in = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {26'd0, got_vec()}, 32'd0);
    drops = 0;
    chk_drops("drop_async_reset");
    in_val = 1'b0; out_rdy_in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_pkt(2, 1'b1, 1'b0, 99, -1, 1'b1);
    send_pkt(4, 1'b1, 1'b0, 99, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_logger_record_ctrl.md
# tcp_logger_record_ctrl

Control FSM for the TCP logger record datapath. Sequences every NoC packet passing through the logger tile, forwarding it unchanged except for a rewritten header destination, and commits one log entry (timestamp, payload length, TCP header) per logged packet. Sits between the noc0 ingress/egress handshakes and the record datapath, which holds all data registers.

## Interface
- `DROP_CNT_W`, default 32: width of the dropped-packet counter; used only when the drop counter is compiled in.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `noc0_logger_record_val` in 1: ingress flit valid.
- `logger_record_noc0_rdy` out 1: ingress ready.
- `logger_record_noc0_val` out 1: egress flit valid.
- `noc0_logger_record_rdy` in 1: egress ready.
- `ctrl_datap_store_hdr` out 1: latch `msg_len` from the current header flit and clear the flit counter.
- `ctrl_datap_mod_hdr_flit` out 1: drive the rewritten header on egress.
- `ctrl_datap_store_len` out 1: latch the payload length from the metadata flit.
- `ctrl_datap_incr_num_flits` out 1: increment the body-flit counter.
- `ctrl_datap_incr_addr` out 1: advance the log write address.
- `ctrl_wr_logger_mem_val` out 1: log memory write enable.
- `datap_ctrl_last_flit` in 1: current body flit is the last one.
- `datap_ctrl_no_body` in 1: current header flit has `msg_len` == 0.
- `datap_ctrl_log_full` in 1: log memory is full.
- `record_en` in 1: logging enable. Forwarding is unaffected by this input.
- `dropped_cnt` out DROP_CNT_W: count of packets not logged because the log was full. Present only with the macro.

## Operation
- Handshake is combinational pass-through:
  - `logger_record_noc0_val` = `noc0_logger_record_val`.
  - `logger_record_noc0_rdy` = `noc0_logger_record_rdy`.
  - A transfer (xfer) occurs when both are high. All control pulses below are qualified by xfer.
- States: HDR, META, TCP_HDR, BODY.
- HDR:
  - On xfer, assert `store_hdr` and `mod_hdr_flit`.
  - Next state: HDR if `no_body`, otherwise META.
  - `mod_hdr_flit` is high in HDR regardless of xfer, so the egress data is stable.
- META (body flit 0):
  - On xfer, assert `store_len` and `incr_num_flits`.
  - Next state: HDR if `last_flit`, with no log write; otherwise TCP_HDR.
- TCP_HDR (body flit 1):
  - On xfer, assert `incr_num_flits`.
  - If `record_en` && !`log_full`, also assert `wr_logger_mem_val` and `incr_addr` in the same cycle.
  - Next state: HDR if `last_flit`, otherwise BODY.
- BODY:
  - On xfer, assert `incr_num_flits`.
  - Next state: HDR on `last_flit`.
- Log full:
  - `log_full` sampled during the TCP_HDR xfer blocks the write.
  - The address never wraps; full persists until reset.
  - The packet is still forwarded intact.
- `record_en` is sampled only at the TCP_HDR xfer. Toggling it mid-packet has no other effect.

## Timing
- Forwarding latency is 0 cycles. No internal buffering; backpressure propagates combinationally.
- All control outputs are combinational from the state, the handshake and the datapath inputs.
- The log entry is written in the same cycle as the TCP header flit xfer. The address increments at that clock edge.
- Reset:
  - Every control output is 0 in reset, except that `logger_record_noc0_val` and `logger_record_noc0_rdy` follow their inputs.
  - State resets to HDR and `dropped_cnt` resets to 0.
- Reset asserted mid-packet returns to HDR immediately. The in-flight packet is truncated; no recovery is attempted.
- Back-to-back packets run with no idle cycle: the last-flit xfer and the next header xfer may be consecutive cycles.

## Configuration
- `TCP_LOGGER_RECORD_DROP_CNT_EN` defined:
  - `dropped_cnt` exists.
  - It increments by 1 on each TCP_HDR xfer where `record_en` && `log_full`.
  - It saturates at all-ones.
- `TCP_LOGGER_RECORD_DROP_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Single packet, `msg_len`=3, `record_en`=1, log empty, sinks always ready:
  - 4 xfers; `mod_hdr_flit` is asserted on cycle 0 only.
  - Exactly one `wr_logger_mem_val`/`incr_addr` pulse, on the 3rd flit.
  - FSM is back in HDR.
- Egress `rdy` low for 5 cycles during TCP_HDR:
  - No write pulse until the xfer, then exactly one pulse.
  - `incr_num_flits` pulses once per flit (3 total).
- `msg_len`=0 header, then `msg_len`=1, then `msg_len`=2, back-to-back:
  - No log writes for the first two packets and one write for the third.
  - No idle cycles between packets.
- `log_full`=1 for 3 packets with `record_en`=1:
  - All packets are forwarded and no writes occur.
  - `dropped_cnt`=3 with the macro defined.
  - Same stimulus with `record_en`=0 leaves `dropped_cnt` at 0.
- With `DROP_CNT_W`=2, drive 5 full-log packets: `dropped_cnt` saturates at 3.
- Assert `rst_n` low during BODY of a 6-flit packet:
  - Outputs drop to reset values asynchronously.
  - After release, a new 3-flit packet is logged normally.
